// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result bundle between the EX-stage control unit and
// the multiply/divide sequencer.
//   start/op/src_a/src_b/flush : request side, driven by the control unit (master)
//   busy/done/hi/lo            : status and HI/LO contents, driven by the unit (slave)
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO, plus MTHI/MTLO.
//   clk   : rising-edge clock
//   rst   : synchronous, active-high reset
//   bus   : muldiv_unit_if.slave
//           start/op/src_a/src_b sampled in IDLE only; flush cancels (priority over all)
//           busy = state != IDLE; done = one-cycle pulse when hi/lo take a mul/div result
// Sequence: IDLE -> CALC (WIDTH iterations) -> FIN (sign fix-up + write) -> IDLE.
// Signed ops run on magnitudes; the result signs are recorded at start and applied in FIN.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;      // mul: {partial product, multiplier}; div: low half = quotient
  logic [WIDTH-1:0]     rem_q, rem_d;      // div partial remainder (always < divisor)
  logic [WIDTH-1:0]     opb_q, opb_d;      // multiplicand / divisor magnitude
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;      // product / quotient negative
  logic                 rem_neg_q, rem_neg_d;
  logic                 div0_q, div0_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 req_md, sgn_op;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]   prod;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
    return en ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? ({(2*WIDTH){1'b0}} - v) : v;
  endfunction

  // request decode and operand magnitudes
  always_comb begin
    req_md = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
             (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    sgn_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    a_s    = bus.src_a;
    b_s    = bus.src_b;
    a_mag  = neg_if(bus.src_a, sgn_op && (a_s < 0));
    b_mag  = neg_if(bus.src_b, sgn_op && (b_s < 0));
  end

  // one iteration of shift-add / restoring shift-subtract
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    prod      = neg2_if(acc_q, neg_q);
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start && !bus.flush && req_md) state_d = CALC;
      CALC:    if (bus.flush) state_d = IDLE;
               else if (cnt_q == CW'(WIDTH-1)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath / output logic
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          if (req_md) begin
            is_div_d  = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
            neg_d     = sgn_op && ((a_s < 0) != (b_s < 0));
            rem_neg_d = sgn_op && (a_s < 0);
            div0_d    = (bus.src_b == '0);
            opb_d     = b_mag;
            acc_d     = {{WIDTH{1'b0}}, a_mag};
            rem_d     = '0;
            cnt_d     = '0;
          end else if (bus.op == OP_MTHI) begin
            hi_d = bus.src_a;
          end else if (bus.op == OP_MTLO) begin
            lo_d = bus.src_a;
          end
        end
      end
      CALC: begin
        cnt_d = (cnt_q == CW'(WIDTH-1)) ? '0 : cnt_q + CW'(1);
        if (!is_div_q) begin
          acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
          rem_d = div_diff[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = div_shift[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
        end
      end
      FIN: begin
        if (!bus.flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // a zero divisor leaves rem = |dividend|, so the sign fix restores src_a in hi
            hi_d = neg_if(rem_q, rem_neg_q);
            lo_d = div0_q ? {WIDTH{1'b1}} : neg_if(acc_q[WIDTH-1:0], neg_q);
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
    acc_q     <= acc_d;
    rem_q     <= rem_d;
    opb_q     <= opb_d;
    is_div_q  <= is_div_d;
    neg_q     <= neg_d;
    rem_neg_q <= rem_neg_d;
    div0_q    <= div0_d;
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;
  int   cycles;
  int   dones;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue a one-cycle request, then wait (bounded) for busy to drop
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    tick();
    bus.start = 1'b0; bus.op = 3'd0;
    busy_cycles = 0;
    while (bus.busy && busy_cycles < 100) begin
      tick();
      busy_cycles++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 3'd0; bus.src_a = '0; bus.src_b = '0; bus.flush = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);

    // MULTU max*max
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, cycles);
    check("multu_max_latency", 64'(cycles), 64'd33);
    check("multu_max_done", 64'(bus.done), 64'd1);
    check("multu_max_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
    tick();
    check("multu_done_pulse_width", 64'(bus.done), 64'd0);

    run_op(3'd1, 32'hFFFFFFFD, 32'd7, cycles);
    check("mult_neg3x7", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFEB);
    run_op(3'd1, 32'h80000000, 32'h80000000, cycles);
    check("mult_min_sq", {bus.hi, bus.lo}, 64'h40000000_00000000);

    run_op(3'd3, 32'hFFFFFFF9, 32'd2, cycles);
    check("div_neg7_2", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(3'd4, 32'd100, 32'd7, cycles);
    check("divu_100_7", {bus.hi, bus.lo}, 64'h00000002_0000000E);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, cycles);
    check("div_min_by_m1", {bus.hi, bus.lo}, 64'h00000000_80000000);

    run_op(3'd4, 32'd5, 32'd0, cycles);
    check("divu_by0_latency", 64'(cycles), 64'd33);
    check("divu_by0_done", 64'(bus.done), 64'd1);
    check("divu_by0", {bus.hi, bus.lo}, 64'h00000005_FFFFFFFF);
    run_op(3'd3, 32'hFFFFFFFB, 32'd0, cycles);
    check("div_neg5_by0", {bus.hi, bus.lo}, 64'hFFFFFFFB_FFFFFFFF);

    // MTHI / MTLO
    tick();
    bus.start = 1'b1; bus.op = 3'd5; bus.src_a = 32'h1234;
    tick();
    bus.start = 1'b0; bus.op = 3'd0;
    check("mthi_hi", 64'(bus.hi), 64'h1234);
    check("mthi_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    bus.start = 1'b1; bus.op = 3'd6; bus.src_a = 32'h5678;
    tick();
    bus.start = 1'b0; bus.op = 3'd0;
    check("mtlo_hilo", {bus.hi, bus.lo}, 64'h00001234_00005678);
    check("mtlo_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);

    // start held and operands changed mid-op
    bus.start = 1'b1; bus.op = 3'd2; bus.src_a = 32'd6; bus.src_b = 32'd7;
    tick();
    bus.src_a = 32'd100; bus.src_b = 32'd100; bus.op = 3'd1;
    cycles = 0;
    while (bus.busy && cycles < 100) begin
      if (cycles == 10) bus.start = 1'b0;
      tick();
      cycles++;
    end
    check("held_start_latency", 64'(cycles), 64'd33);
    check("held_start_result", {bus.hi, bus.lo}, 64'd42);
    tick();
    check("held_start_no_reissue", 64'(bus.busy), 64'd0);

    // flush at cycle 10 of a DIV
    bus.start = 1'b1; bus.op = 3'd4; bus.src_a = 32'd1000; bus.src_b = 32'd3;
    tick();
    bus.start = 1'b0; bus.op = 3'd0;
    repeat (9) tick();
    check("flush_busy_before", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_busy_after", 64'(bus.busy), 64'd0);
    dones = 0;
    repeat (40) begin
      tick();
      if (bus.done) dones++;
    end
    check("flush_no_done", 64'(dones), 64'd0);
    check("flush_hilo_kept", {bus.hi, bus.lo}, 64'd42);

    // flush beats start in IDLE
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd5; bus.src_a = 32'hDEAD;
    tick();
    check("idle_flush_mthi", 64'(bus.hi), 64'd0);
    bus.op = 3'd2;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'd0;
    check("idle_flush_multu", 64'(bus.busy), 64'd0);

    // reset at cycle 20 of a MULT
    bus.start = 1'b1; bus.op = 3'd1; bus.src_a = 32'd5; bus.src_b = 32'd5;
    tick();
    bus.start = 1'b0; bus.op = 3'd0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    check("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
    repeat (40) tick();
    check("rst_mid_no_result", {bus.hi, bus.lo}, 64'd0);

    // back-to-back issue in the done cycle
    run_op(3'd2, 32'd3, 32'd4, cycles);
    check("b2b_first", {31'd0, bus.done, bus.lo}, {31'd0, 1'b1, 32'd12});
    bus.start = 1'b1; bus.op = 3'd2; bus.src_a = 32'd5; bus.src_b = 32'd6;
    cycles = 0;
    do begin
      tick();
      cycles++;
      if (cycles == 1) begin bus.start = 1'b0; bus.op = 3'd0; end
    end while (!bus.done && cycles < 100);
    check("b2b_done_spacing", 64'(cycles), 64'd34);
    check("b2b_second", {bus.hi, bus.lo}, 64'd30);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
